// File: rtl/dual_mem_arb_if.sv
// Bus bundle between two cores, the shared data memory and the arbiter.
// The slave modport is the arbiter's view; master is the cores/memory side.
interface dual_mem_arb_if;
    // Core 0
    logic        c0_ren;
    logic [14:0] c0_raddr;
    logic        c0_wen;
    logic [14:0] c0_waddr;
    logic [15:0] c0_wdata;
    logic        c0_stall;
    logic        c0_rvalid;
    logic [15:0] c0_rdata;
    // Core 1
    logic        c1_ren;
    logic [14:0] c1_raddr;
    logic        c1_wen;
    logic [14:0] c1_waddr;
    logic [15:0] c1_wdata;
    logic        c1_stall;
    logic        c1_rvalid;
    logic [15:0] c1_rdata;
    // Memory
    logic        m_ren;
    logic [14:0] m_raddr;
    logic [15:0] m_rdata;
    logic        m_wen;
    logic [14:0] m_waddr;
    logic [15:0] m_wdata;

    modport slave (
        input  c0_ren, c0_raddr, c0_wen, c0_waddr, c0_wdata,
        output c0_stall, c0_rvalid, c0_rdata,
        input  c1_ren, c1_raddr, c1_wen, c1_waddr, c1_wdata,
        output c1_stall, c1_rvalid, c1_rdata,
        output m_ren, m_raddr, m_wen, m_waddr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c0_ren, c0_raddr, c0_wen, c0_waddr, c0_wdata,
        input  c0_stall, c0_rvalid, c0_rdata,
        output c1_ren, c1_raddr, c1_wen, c1_waddr, c1_wdata,
        input  c1_stall, c1_rvalid, c1_rdata,
        input  m_ren, m_raddr, m_wen, m_waddr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dual_mem_arb.sv
// Two-core arbiter for a shared single-read/single-write data memory.
// Same-kind conflicts are resolved by one rotating priority bit; the loser
// stalls for the whole cycle. Read data is steered back by a tag pipeline
// whose depth matches the memory read latency.
module dual_mem_arb #(
    parameter int unsigned RD_LAT = 2  // legal 1..7
) (
    input  logic              clk,
    input  logic              rst,
    dual_mem_arb_if.slave     bus,
    output logic              rd_busy,
    output logic [15:0]       stall_cnt
);

    logic              pri;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_id;

    logic rd_conf;
    logic wr_conf;
    logic conf;
    logic g0_r;
    logic g1_r;
    logic g0_w;
    logic g1_w;
    logic tail_v;
    logic tail_id;

    // Conflict detection, stall and grant selection
    always_comb begin
        rd_conf = bus.c0_ren & bus.c1_ren;
        wr_conf = bus.c0_wen & bus.c1_wen;
        conf    = rd_conf | wr_conf;
        // A single shared priority bit means exactly one core loses
        bus.c0_stall = conf & pri;
        bus.c1_stall = conf & ~pri;
        // A stalled core issues nothing on either channel
        g0_r = bus.c0_ren & ~bus.c0_stall;
        g1_r = bus.c1_ren & ~bus.c1_stall;
        g0_w = bus.c0_wen & ~bus.c0_stall;
        g1_w = bus.c1_wen & ~bus.c1_stall;
    end

    // Memory issue muxes; idle channels drive zeros
    always_comb begin
        bus.m_ren   = g0_r | g1_r;
        bus.m_raddr = '0;
        if (g0_r) begin
            bus.m_raddr = bus.c0_raddr;
        end else if (g1_r) begin
            bus.m_raddr = bus.c1_raddr;
        end
        bus.m_wen   = g0_w | g1_w;
        bus.m_waddr = '0;
        bus.m_wdata = '0;
        if (g0_w) begin
            bus.m_waddr = bus.c0_waddr;
            bus.m_wdata = bus.c0_wdata;
        end else if (g1_w) begin
            bus.m_waddr = bus.c1_waddr;
            bus.m_wdata = bus.c1_wdata;
        end
    end

    // Read return steering from the pipeline tail
    always_comb begin
        tail_v        = tag_v[RD_LAT-1];
        tail_id       = tag_id[RD_LAT-1];
        bus.c0_rvalid = tail_v & ~tail_id;
        bus.c1_rvalid = tail_v & tail_id;
        bus.c0_rdata  = bus.c0_rvalid ? bus.m_rdata : '0;
        bus.c1_rdata  = bus.c1_rvalid ? bus.m_rdata : '0;
        rd_busy       = |tag_v;
    end

    // Priority rotation: toggle only after a cycle with a conflict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri <= 1'b0;
        end else if (conf) begin
            pri <= ~pri;
        end
    end

    // Tag pipeline: stage 0 captures this cycle's read issue and its owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= bus.m_ren;
            tag_id[0] <= g1_r;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Saturating count of cycles in which some core was stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((bus.c0_stall | bus.c1_stall) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dual_mem_arb.sv
// Self-checking bench for dual_mem_arb: directed read-latency, pipelining and
// mid-flight reset sequences, then a table of per-cycle arbitration vectors.
module tb_dual_mem_arb;

    localparam int unsigned RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic        rd_busy;
    logic [15:0] stall_cnt;

    dual_mem_arb_if bus ();

    dual_mem_arb #(.RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .rd_busy   (rd_busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple memory model: fixed-latency read of a small preloaded array
    logic [15:0] mem [0:255];
    logic [14:0] pa  [RD_LAT];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[8'h10] = 16'hBEEF;
        mem[8'h40] = 16'hC0DE;
    end

    always @(posedge clk) begin
        pa[0] <= bus.m_raddr;
        for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
    end

    assign bus.m_rdata = mem[pa[RD_LAT-1][7:0]];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        bus.c0_ren = 1'b0; bus.c0_raddr = '0; bus.c0_wen = 1'b0;
        bus.c0_waddr = '0; bus.c0_wdata = '0;
        bus.c1_ren = 1'b0; bus.c1_raddr = '0; bus.c1_wen = 1'b0;
        bus.c1_waddr = '0; bus.c1_wdata = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " c0_stall"},  32'(bus.c0_stall),  32'd0);
        chk({tag, " c1_stall"},  32'(bus.c1_stall),  32'd0);
        chk({tag, " c0_rvalid"}, 32'(bus.c0_rvalid), 32'd0);
        chk({tag, " c1_rvalid"}, 32'(bus.c1_rvalid), 32'd0);
        chk({tag, " c0_rdata"},  32'(bus.c0_rdata),  32'd0);
        chk({tag, " c1_rdata"},  32'(bus.c1_rdata),  32'd0);
        chk({tag, " rd_busy"},   32'(rd_busy),       32'd0);
        chk({tag, " m_ren"},     32'(bus.m_ren),     32'd0);
        chk({tag, " m_raddr"},   32'(bus.m_raddr),   32'd0);
        chk({tag, " m_wen"},     32'(bus.m_wen),     32'd0);
        chk({tag, " m_waddr"},   32'(bus.m_waddr),   32'd0);
        chk({tag, " m_wdata"},   32'(bus.m_wdata),   32'd0);
    endtask

    typedef struct {
        logic        c0_ren;
        logic [14:0] c0_raddr;
        logic        c0_wen;
        logic [14:0] c0_waddr;
        logic [15:0] c0_wdata;
        logic        c1_ren;
        logic [14:0] c1_raddr;
        logic        c1_wen;
        logic [14:0] c1_waddr;
        logic [15:0] c1_wdata;
        logic        s0;
        logic        s1;
        logic        mren;
        logic [14:0] mraddr;
        logic        mwen;
        logic [14:0] mwaddr;
        logic [15:0] mwdata;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    initial begin
        // Vectors assume pri=0 and stall_cnt=0 at vector 0, one cycle each.
        //          c0: ren raddr     wen waddr     wdata      c1: ren raddr     wen waddr     wdata
        //          exp: s0 s1 mren mraddr mwen mwaddr mwdata cnt
        vt[0]  = '{1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000,
                   1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 16'd0};
        // Write-write conflicts alternate winners
        vt[1]  = '{1'b0, 15'h0000, 1'b1, 15'h0001, 16'hAAAA, 1'b0, 15'h0000, 1'b1, 15'h0002, 16'h5555,
                   1'b0, 1'b1, 1'b0, 15'h0000, 1'b1, 15'h0001, 16'hAAAA, 16'd0};
        vt[2]  = '{1'b0, 15'h0000, 1'b1, 15'h0001, 16'hAAAA, 1'b0, 15'h0000, 1'b1, 15'h0002, 16'h5555,
                   1'b1, 1'b0, 1'b0, 15'h0000, 1'b1, 15'h0002, 16'h5555, 16'd1};
        vt[3]  = '{1'b0, 15'h0000, 1'b1, 15'h0001, 16'hAAAA, 1'b0, 15'h0000, 1'b1, 15'h0002, 16'h5555,
                   1'b0, 1'b1, 1'b0, 15'h0000, 1'b1, 15'h0001, 16'hAAAA, 16'd2};
        vt[4]  = '{1'b0, 15'h0000, 1'b1, 15'h0001, 16'hAAAA, 1'b0, 15'h0000, 1'b1, 15'h0002, 16'h5555,
                   1'b1, 1'b0, 1'b0, 15'h0000, 1'b1, 15'h0002, 16'h5555, 16'd3};
        // c0 writes, c1 reads: no conflict, both issued, pri stays 0
        vt[5]  = '{1'b0, 15'h0000, 1'b1, 15'h0030, 16'h1234, 1'b1, 15'h0040, 1'b0, 15'h0000, 16'h0000,
                   1'b0, 1'b0, 1'b1, 15'h0040, 1'b1, 15'h0030, 16'h1234, 16'd4};
        // Read conflict while c1 also writes: c1 loses both channels
        vt[6]  = '{1'b1, 15'h0050, 1'b0, 15'h0000, 16'h0000, 1'b1, 15'h0060, 1'b1, 15'h0070, 16'h7777,
                   1'b0, 1'b1, 1'b1, 15'h0050, 1'b0, 15'h0000, 16'h0000, 16'd4};
        // c1 holds; c0 gone: both of c1's requests issue
        vt[7]  = '{1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 1'b1, 15'h0060, 1'b1, 15'h0070, 16'h7777,
                   1'b0, 1'b0, 1'b1, 15'h0060, 1'b1, 15'h0070, 16'h7777, 16'd5};
        // pri=1 now: read conflict goes to c1, c0's non-conflicting write is blocked
        vt[8]  = '{1'b1, 15'h0011, 1'b1, 15'h0021, 16'h4444, 1'b1, 15'h0012, 1'b0, 15'h0000, 16'h0000,
                   1'b1, 1'b0, 1'b1, 15'h0012, 1'b0, 15'h0000, 16'h0000, 16'd5};
        vt[9]  = '{1'b1, 15'h0011, 1'b1, 15'h0021, 16'h4444, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000,
                   1'b0, 1'b0, 1'b1, 15'h0011, 1'b1, 15'h0021, 16'h4444, 16'd6};
        vt[10] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000,
                   1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 16'd6};
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk_quiet("reset");
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);

        // Release reset; this is cycle 0
        next_cycle();
        rst = 1'b0;
        settle();
        chk_quiet("cyc0");
        next_cycle();
        next_cycle();

        // Cycle 3: lone read by c0
        next_cycle();
        bus.c0_ren = 1'b1; bus.c0_raddr = 15'h0010;
        settle();
        chk("cyc3 m_ren", 32'(bus.m_ren), 32'd1);
        chk("cyc3 m_raddr", 32'(bus.m_raddr), 32'h10);
        chk("cyc3 c0_stall", 32'(bus.c0_stall), 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        chk("cyc4 c0_rvalid", 32'(bus.c0_rvalid), 32'd0);
        chk("cyc4 rd_busy", 32'(rd_busy), 32'd1);
        next_cycle();
        settle();
        chk("cyc5 c0_rvalid", 32'(bus.c0_rvalid), 32'd1);
        chk("cyc5 c0_rdata", 32'(bus.c0_rdata), 32'hBEEF);
        chk("cyc5 c1_rvalid", 32'(bus.c1_rvalid), 32'd0);
        chk("cyc5 c1_rdata", 32'(bus.c1_rdata), 32'd0);

        // Back-to-back reads from different cores
        next_cycle();
        bus.c0_ren = 1'b1; bus.c0_raddr = 15'h0010;
        next_cycle();
        idle_inputs();
        bus.c1_ren = 1'b1; bus.c1_raddr = 15'h0040;
        next_cycle();
        idle_inputs();
        settle();
        chk("pipe c0_rvalid", 32'(bus.c0_rvalid), 32'd1);
        chk("pipe c0_rdata", 32'(bus.c0_rdata), 32'hBEEF);
        chk("pipe c1_rvalid early", 32'(bus.c1_rvalid), 32'd0);
        next_cycle();
        settle();
        chk("pipe c1_rvalid", 32'(bus.c1_rvalid), 32'd1);
        chk("pipe c1_rdata", 32'(bus.c1_rdata), 32'hC0DE);
        chk("pipe c0_rvalid late", 32'(bus.c0_rvalid), 32'd0);
        next_cycle();

        // Reads in two consecutive cycles, reset asserted during the second
        bus.c0_ren = 1'b1; bus.c0_raddr = 15'h0010;
        next_cycle();
        bus.c0_raddr = 15'h0040;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst rd_busy", 32'(rd_busy), 32'd0);
        chk("midrst stall_cnt", 32'(stall_cnt), 32'd0);
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        settle();
        chk("post-rst1 c0_rvalid", 32'(bus.c0_rvalid), 32'd0);
        chk("post-rst1 c0_rdata", 32'(bus.c0_rdata), 32'd0);
        chk("post-rst1 rd_busy", 32'(rd_busy), 32'd0);
        next_cycle();
        settle();
        chk_quiet("post-rst2");

        // Arbitration table, starting from pri=0, stall_cnt=0
        for (int v = 0; v < NV; v++) begin
            next_cycle();
            bus.c0_ren = vt[v].c0_ren; bus.c0_raddr = vt[v].c0_raddr;
            bus.c0_wen = vt[v].c0_wen; bus.c0_waddr = vt[v].c0_waddr;
            bus.c0_wdata = vt[v].c0_wdata;
            bus.c1_ren = vt[v].c1_ren; bus.c1_raddr = vt[v].c1_raddr;
            bus.c1_wen = vt[v].c1_wen; bus.c1_waddr = vt[v].c1_waddr;
            bus.c1_wdata = vt[v].c1_wdata;
            settle();
            chk($sformatf("vec%0d c0_stall", v), 32'(bus.c0_stall), 32'(vt[v].s0));
            chk($sformatf("vec%0d c1_stall", v), 32'(bus.c1_stall), 32'(vt[v].s1));
            chk($sformatf("vec%0d m_ren", v),    32'(bus.m_ren),    32'(vt[v].mren));
            chk($sformatf("vec%0d m_raddr", v),  32'(bus.m_raddr),  32'(vt[v].mraddr));
            chk($sformatf("vec%0d m_wen", v),    32'(bus.m_wen),    32'(vt[v].mwen));
            chk($sformatf("vec%0d m_waddr", v),  32'(bus.m_waddr),  32'(vt[v].mwaddr));
            chk($sformatf("vec%0d m_wdata", v),  32'(bus.m_wdata),  32'(vt[v].mwdata));
            chk($sformatf("vec%0d stall_cnt", v), 32'(stall_cnt),   32'(vt[v].cnt));
        end

        next_cycle();
        idle_inputs();
        settle();
        chk("final stall_cnt", 32'(stall_cnt), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
